// File: rtl/spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// spi_cmd_sequencer
//
// Purpose:
//   Command/response front end placed directly upstream of an SPI master.
//   Transfer commands (data word + bit count) are queued in a small FIFO and
//   issued to the master one at a time. The block then follows the master's
//   chip select to detect completion and captures the received word into a
//   response FIFO. A per-phase watchdog aborts a transfer whose chip select
//   never moves, so the consumer always receives exactly one response per
//   accepted command. That response is flagged with rsp_err on a timeout.
//
// Ports:
//   sys_clk    in   system clock, shared with the SPI master
//   rst        in   asynchronous active-high reset
//   cmd_valid  in   command offered
//   cmd_ready  out  command FIFO not full
//   cmd_data   in   [REG_WIDTH] word to shift out, MSB first
//   cmd_size   in   [CW+1] bits to transfer, clamped to REG_WIDTH on push
//   rsp_valid  out  response FIFO not empty
//   rsp_ready  in   consumer takes the head response
//   rsp_data   out  [REG_WIDTH] received word (0 when empty)
//   rsp_err    out  head response came from a watchdog abort (0 when empty)
//   busy       out  transfer in flight or command FIFO non-empty
//   m_t_start  out  to master t_start
//   m_d_in     out  [REG_WIDTH] to master d_in, held until the next issue
//   m_t_size   out  [CW+1] to master t_size, held until the next issue
//   m_d_out    in   [REG_WIDTH] from master d_out, valid once cs is high again
//   m_cs       in   from master cs (active low)
// -----------------------------------------------------------------------------
module spi_cmd_sequencer #(
    parameter int REG_WIDTH = 8,
    parameter int CW        = $clog2(REG_WIDTH),
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [REG_WIDTH-1:0] cmd_data,
    input  logic [CW:0]          cmd_size,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [REG_WIDTH-1:0] rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 m_t_start,
    output logic [REG_WIDTH-1:0] m_d_in,
    output logic [CW:0]          m_t_size,
    input  logic [REG_WIDTH-1:0] m_d_out,
    input  logic                 m_cs
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int SZ_W  = CW + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(DEPTH);
    localparam logic [SZ_W-1:0]  SIZE_MAX  = SZ_W'(REG_WIDTH);
    localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        CAPTURE
    } state_t;

    // -------------------------------------------------------------------------
    // Command FIFO
    // -------------------------------------------------------------------------
    logic [REG_WIDTH-1:0] cmd_data_mem [DEPTH];
    logic [SZ_W-1:0]      cmd_size_mem [DEPTH];

    logic [AW-1:0]        cmd_wr_ptr_q, cmd_wr_ptr_d;
    logic [AW-1:0]        cmd_rd_ptr_q, cmd_rd_ptr_d;
    logic [CNT_W-1:0]     cmd_cnt_q, cmd_cnt_d;
    logic                 cmd_push;
    logic                 cmd_pop;
    logic                 cmd_empty;
    logic [SZ_W-1:0]      cmd_size_clamped;
    logic [REG_WIDTH-1:0] cmd_head_data;
    logic [SZ_W-1:0]      cmd_head_size;

    assign cmd_empty        = (cmd_cnt_q == '0);
    assign cmd_ready        = (cmd_cnt_q != FIFO_FULL);
    assign cmd_push         = cmd_valid && cmd_ready;
    assign cmd_size_clamped = (cmd_size > SIZE_MAX) ? SIZE_MAX : cmd_size;
    assign cmd_head_data    = cmd_data_mem[cmd_rd_ptr_q];
    assign cmd_head_size    = cmd_size_mem[cmd_rd_ptr_q];

    // NOTE: the storage arrays carry no reset. Occupancy lives in the
    // pointers and counts, and every visible output is gated on non-empty,
    // so stale entries can never leak out after a reset.
    always_ff @(posedge sys_clk) begin
        if (cmd_push) begin
            cmd_data_mem[cmd_wr_ptr_q] <= cmd_data;
            cmd_size_mem[cmd_wr_ptr_q] <= cmd_size_clamped;
        end
    end

    always_comb begin
        cmd_wr_ptr_d = cmd_wr_ptr_q;
        cmd_rd_ptr_d = cmd_rd_ptr_q;
        cmd_cnt_d    = cmd_cnt_q;
        if (cmd_push) begin
            cmd_wr_ptr_d = cmd_wr_ptr_q + AW'(1);
        end
        if (cmd_pop) begin
            cmd_rd_ptr_d = cmd_rd_ptr_q + AW'(1);
        end
        case ({cmd_push, cmd_pop})
            2'b10:   cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
            2'b01:   cmd_cnt_d = cmd_cnt_q - CNT_W'(1);
            default: cmd_cnt_d = cmd_cnt_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Response FIFO
    // -------------------------------------------------------------------------
    logic [REG_WIDTH-1:0] rsp_data_mem [DEPTH];
    logic                 rsp_err_mem  [DEPTH];

    logic [AW-1:0]        rsp_wr_ptr_q, rsp_wr_ptr_d;
    logic [AW-1:0]        rsp_rd_ptr_q, rsp_rd_ptr_d;
    logic [CNT_W-1:0]     rsp_cnt_q, rsp_cnt_d;
    logic                 rsp_push;
    logic                 rsp_push_ok;
    logic                 rsp_pop;
    logic                 rsp_full;

    assign rsp_full    = (rsp_cnt_q == FIFO_FULL);
    assign rsp_valid   = (rsp_cnt_q != '0);
    assign rsp_pop     = rsp_valid && rsp_ready;
    // A push into a full FIFO is only accepted when the head leaves in the
    // same cycle; the count then stays at DEPTH.
    assign rsp_push_ok = rsp_push && (!rsp_full || rsp_pop);
    assign rsp_data    = rsp_valid ? rsp_data_mem[rsp_rd_ptr_q] : '0;
    assign rsp_err     = rsp_valid ? rsp_err_mem[rsp_rd_ptr_q]  : 1'b0;

    logic [REG_WIDTH-1:0] cap_data_q, cap_data_d;
    logic                 cap_err_q, cap_err_d;

    always_ff @(posedge sys_clk) begin
        if (rsp_push_ok) begin
            rsp_data_mem[rsp_wr_ptr_q] <= cap_data_q;
            rsp_err_mem[rsp_wr_ptr_q]  <= cap_err_q;
        end
    end

    always_comb begin
        rsp_wr_ptr_d = rsp_wr_ptr_q;
        rsp_rd_ptr_d = rsp_rd_ptr_q;
        rsp_cnt_d    = rsp_cnt_q;
        if (rsp_push_ok) begin
            rsp_wr_ptr_d = rsp_wr_ptr_q + AW'(1);
        end
        if (rsp_pop) begin
            rsp_rd_ptr_d = rsp_rd_ptr_q + AW'(1);
        end
        case ({rsp_push_ok, rsp_pop})
            2'b10:   rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
            2'b01:   rsp_cnt_d = rsp_cnt_q - CNT_W'(1);
            default: rsp_cnt_d = rsp_cnt_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Transfer sequencer
    // -------------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [WD_W-1:0]      wd_inc;
    logic                 m_t_start_q, m_t_start_d;
    logic [REG_WIDTH-1:0] m_d_in_q, m_d_in_d;
    logic [SZ_W-1:0]      m_t_size_q, m_t_size_d;

    // Watchdog saturates so a long stall cannot wrap back to a small value.
    assign wd_inc = (wd_q == WD_LIMIT) ? wd_q : wd_q + WD_W'(1);

    // NOTE: every signal driven here gets a default before the case, so no
    // path through the block leaves a value unassigned and no latch is built.
    always_comb begin
        state_d     = state_q;
        wd_d        = '0;
        m_t_start_d = m_t_start_q;
        m_d_in_d    = m_d_in_q;
        m_t_size_d  = m_t_size_q;
        cap_data_d  = cap_data_q;
        cap_err_d   = cap_err_q;
        cmd_pop     = 1'b0;
        rsp_push    = 1'b0;

        case (state_q)
            IDLE: begin
                // Only one transfer is ever in flight, so checking for
                // response space here guarantees the CAPTURE push fits.
                if (!cmd_empty && !rsp_full) begin
                    cmd_pop = 1'b1;
                    if (cmd_head_size == '0) begin
                        cap_data_d = '0;
                        cap_err_d  = 1'b0;
                        state_d    = CAPTURE;
                    end else begin
                        m_d_in_d    = cmd_head_data;
                        m_t_size_d  = cmd_head_size;
                        m_t_start_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end
            end

            ISSUE: begin
                state_d = WAIT_LOW;
            end

            WAIT_LOW: begin
                wd_d = wd_inc;
                if (!m_cs) begin
                    // Master has started; drop t_start so it returns to idle
                    // after unloading instead of chaining another transfer.
                    m_t_start_d = 1'b0;
                    wd_d        = '0;
                    state_d     = WAIT_HIGH;
                end else if (wd_q == WD_LIMIT) begin
                    m_t_start_d = 1'b0;
                    cap_data_d  = '0;
                    cap_err_d   = 1'b1;
                    state_d     = CAPTURE;
                end
            end

            WAIT_HIGH: begin
                wd_d = wd_inc;
                if (m_cs) begin
                    cap_data_d = m_d_out;
                    cap_err_d  = 1'b0;
                    state_d    = CAPTURE;
                end else if (wd_q == WD_LIMIT) begin
                    m_t_start_d = 1'b0;
                    cap_data_d  = '0;
                    cap_err_d   = 1'b1;
                    state_d     = CAPTURE;
                end
            end

            CAPTURE: begin
                rsp_push = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cmd_wr_ptr_q <= '0;
            cmd_rd_ptr_q <= '0;
            cmd_cnt_q    <= '0;
            rsp_wr_ptr_q <= '0;
            rsp_rd_ptr_q <= '0;
            rsp_cnt_q    <= '0;
            state_q      <= IDLE;
            wd_q         <= '0;
            m_t_start_q  <= 1'b0;
            m_d_in_q     <= '0;
            m_t_size_q   <= '0;
            cap_data_q   <= '0;
            cap_err_q    <= 1'b0;
        end else begin
            cmd_wr_ptr_q <= cmd_wr_ptr_d;
            cmd_rd_ptr_q <= cmd_rd_ptr_d;
            cmd_cnt_q    <= cmd_cnt_d;
            rsp_wr_ptr_q <= rsp_wr_ptr_d;
            rsp_rd_ptr_q <= rsp_rd_ptr_d;
            rsp_cnt_q    <= rsp_cnt_d;
            state_q      <= state_d;
            wd_q         <= wd_d;
            m_t_start_q  <= m_t_start_d;
            m_d_in_q     <= m_d_in_d;
            m_t_size_q   <= m_t_size_d;
            cap_data_q   <= cap_data_d;
            cap_err_q    <= cap_err_d;
        end
    end

    assign m_t_start = m_t_start_q;
    assign m_d_in    = m_d_in_q;
    assign m_t_size  = m_t_size_q;
    assign busy      = (state_q != IDLE) || !cmd_empty;

endmodule
